mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the orion pipeline, directly downstream of execute.
//  - Registers the EX result and owns the data-memory request/response handshake.
//  - Aligns and sign/zero-extends load data, then delivers one writeback beat per retired instruction.
//  - Stalls execute (ex_ready_o=0) while a memory access is outstanding.
// PARAMETERS
//  XLEN   32  datapath width
//  ADDRW  32  byte address width
//  MASKW  4   byte-enable width (XLEN/8)
// PORTS
//  clk_i             in   1      clock
//  rst_i             in   1      asynchronous reset, active-low
//  ex_valid_i        in   1      EX result valid
//  ex_ready_o        out  1      stage accepts EX result this cycle
//  ex_rd_s_i         in   5      destination register
//  ex_rd_we_i        in   1      destination write enable
//  ex_rd_v_i         in   XLEN   ALU result; byte address for ld/st
//  ex_is_load_i      in   1      load instruction
//  ex_is_store_i     in   1      store instruction
//  ex_ld_str_type_i  in   3      funct3: B=000 H=001 W=010 BU=100 HU=101
//  ex_st_data_i      in   XLEN   unaligned store data (rs2)
//  dmem_valid_o      out  1      request valid
//  dmem_ready_i      in   1      request accepted
//  dmem_addr_o       out  ADDRW  word-aligned address {addr[ADDRW-1:2],2'b00}
//  dmem_mask_o       out  MASKW  byte enables
//  dmem_wdata_o      out  XLEN   lane-aligned store data
//  dmem_we_o         out  1      1=store
//  dmem_rvalid_i     in   1      load response valid
//  dmem_rdata_i      in   XLEN   load response word
//  wb_valid_o        out  1      writeback beat (1-cycle pulse)
//  wb_rd_s_o         out  5      writeback register
//  wb_rd_we_o        out  1      writeback enable (0 for stores, x0, faults)
//  wb_rd_v_o         out  XLEN   writeback value
//  misaligned_o      out  1      1-cycle pulse, coincident with wb_valid_o, on a misaligned access
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except ex_ready_o=1; internal registers cleared.
//  FSM states IDLE, REQ, RSP. ex_ready_o = (state==IDLE).
//  IDLE, ex_valid_i=1: capture all ex_* inputs.
//   - non-mem: wb_* load next cycle (latency 1); stay IDLE.
//   - misaligned (H/HU addr[0]!=0; W addr[1:0]!=0): no dmem request; wb_valid_o=1, wb_rd_we_o=0, misaligned_o=1 next cycle; stay IDLE.
//   - aligned ld/st: go to REQ; wb_valid_o=0 next cycle.
//  IDLE, ex_valid_i=0: wb_valid_o=0 next cycle.
//  REQ: dmem_valid_o=1 with stable addr/mask/wdata/we until dmem_ready_i.
//   - store accepted: wb pulse (rd_we=0) next cycle; go IDLE.
//   - load accepted: go RSP.
//  RSP: dmem_valid_o=0; wait for dmem_rvalid_i (any latency, earliest the cycle after acceptance).
//   - on rvalid: wb pulse next cycle with formatted data; go IDLE.
//  dmem_valid_o is 0 in IDLE and RSP; it is driven from state only, never from dmem_ready_i.
//  Mask: B/BU 4'b0001<<a[1:0]; H/HU 4'b0011<<a[1:0]; W 4'b1111.
//  Store wdata: B byte placed at lane a[1:0]; H half placed at lane a[1]; W unchanged. Unused lanes are 0.
//  Load format:
//   - extract byte a[1:0] or half a[1]; B/H sign-extend, BU/HU zero-extend, W raw.
//   - undefined funct3 on a load writes 0.
//  wb_rd_we_o = captured rd_we && load/non-mem && !misaligned && rd_s!=0.
//  Stage back-to-back: accepts a new EX result in the same cycle the previous wb pulse is emitted.
//  rvalid arriving outside RSP is ignored. ready arriving outside REQ is ignored.
//  Async reset mid-REQ/RSP returns to IDLE immediately; the pending access is dropped with no wb.
// TESTING
//  ADD rd=5 v=0x1234 -> wb_valid t+1, rd_s=5, rd_we=1, v=0x1234; ex_ready_o stays 1.
//  LB addr=0x1003, rdata=0x80FF_FF00 -> mask 4'b1000, dmem_addr 0x1000, wb v=0xFFFF_FF80.
//  LHU addr=0x2002, rdata=0xBEEF_0000, rvalid 4 cycles after ready -> v=0x0000_BEEF; ex_ready_o low throughout.
//  SB addr=0x3001 data=0xAA, ready held low 3 cycles -> valid/addr/mask 4'b0010/wdata 0x0000_AA00 stable; wb rd_we=0.
//  LW addr=0x4002 -> no dmem_valid_o; wb_valid_o=1, rd_we=0, misaligned_o=1 next cycle.
//  rst_i low while in RSP, then rvalid -> no wb pulse; ex_ready_o=1; next ADD retires normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the orion memory stage (master)
// and the data memory (slave).
interface mem_stage_if #(
  parameter int XLEN  = 32,
  parameter int ADDRW = 32,
  parameter int MASKW = XLEN / 8
);
  logic             dmem_valid_o;
  logic             dmem_ready_i;
  logic [ADDRW-1:0] dmem_addr_o;
  logic [MASKW-1:0] dmem_mask_o;
  logic [XLEN-1:0]  dmem_wdata_o;
  logic             dmem_we_o;
  logic             dmem_rvalid_i;
  logic [XLEN-1:0]  dmem_rdata_i;

  modport master (
    output dmem_valid_o, dmem_addr_o, dmem_mask_o, dmem_wdata_o, dmem_we_o,
    input  dmem_ready_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_valid_o, dmem_addr_o, dmem_mask_o, dmem_wdata_o, dmem_we_o,
    output dmem_ready_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// Orion memory stage: registers the EX result, runs the data-memory handshake,
// formats load data and emits one writeback pulse per retired instruction.
module mem_stage #(
  parameter int XLEN  = 32,
  parameter int ADDRW = 32,
  parameter int MASKW = XLEN / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // execute side
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [4:0]       ex_rd_s_i,
  input  logic             ex_rd_we_i,
  input  logic [XLEN-1:0]  ex_rd_v_i,
  input  logic             ex_is_load_i,
  input  logic             ex_is_store_i,
  input  logic [2:0]       ex_ld_str_type_i,
  input  logic [XLEN-1:0]  ex_st_data_i,
  // data memory
  mem_stage_if.master      dmem,
  // writeback side
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_s_o,
  output logic             wb_rd_we_o,
  output logic [XLEN-1:0]  wb_rd_v_o,
  output logic             misaligned_o
);

  localparam int LW = $clog2(MASKW);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t state_q, state_d;

  // captured EX result
  logic [4:0]       rd_s_q;
  logic             rd_we_q;
  logic [LW-1:0]    lane_q;
  logic [2:0]       type_q;
  logic [ADDRW-1:0] addr_q;
  logic [MASKW-1:0] mask_q;
  logic [XLEN-1:0]  wdata_q;
  logic             we_q;

  // writeback registers
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_s_q, wb_rd_s_d;
  logic             wb_rd_we_q, wb_rd_we_d;
  logic [XLEN-1:0]  wb_rd_v_q, wb_rd_v_d;
  logic             misal_q, misal_d;

  logic             cap_en;

  // ---------------------------------------------------------------------------
  // Decode of the incoming EX result
  // ---------------------------------------------------------------------------
  logic [ADDRW-1:0] ex_addr;
  logic [LW-1:0]    ex_lane;
  logic             ex_is_mem;
  logic             ex_misal;
  logic [MASKW-1:0] ex_mask;
  logic [XLEN-1:0]  ex_wdata;

  assign ex_addr   = ADDRW'(ex_rd_v_i);
  assign ex_lane   = ex_addr[LW-1:0];
  assign ex_is_mem = ex_is_load_i | ex_is_store_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ex_misal = 1'b0;
    ex_mask  = '0;
    ex_wdata = '0;
    unique case (ex_ld_str_type_i)
      F3_B, F3_BU: begin
        ex_mask  = MASKW'(1) << ex_lane;
        ex_wdata = XLEN'(ex_st_data_i[7:0]) << {ex_lane, 3'b000};
      end
      F3_H, F3_HU: begin
        ex_misal = ex_lane[0];
        ex_mask  = MASKW'(3) << ex_lane;
        ex_wdata = XLEN'(ex_st_data_i[15:0]) << {ex_lane[LW-1], 4'b0000};
      end
      F3_W: begin
        ex_misal = (ex_lane != '0);
        ex_mask  = '1;
        ex_wdata = ex_st_data_i;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ld_byte_sh;
  logic [XLEN-1:0] ld_half_sh;
  logic [XLEN-1:0] ld_data;

  assign ld_byte_sh = dmem.dmem_rdata_i >> {lane_q, 3'b000};
  assign ld_half_sh = dmem.dmem_rdata_i >> {lane_q[LW-1], 4'b0000};

  always_comb begin
    ld_data = '0;
    unique case (type_q)
      F3_B:    ld_data = {{(XLEN-8){ld_byte_sh[7]}}, ld_byte_sh[7:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte_sh[7:0]};
      F3_H:    ld_data = {{(XLEN-16){ld_half_sh[15]}}, ld_half_sh[15:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half_sh[15:0]};
      F3_W:    ld_data = dmem.dmem_rdata_i;
      default: ld_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and writeback next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_s_d  = wb_rd_s_q;
    wb_rd_we_d = 1'b0;
    wb_rd_v_d  = wb_rd_v_q;
    misal_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          cap_en = 1'b1;
          if (!ex_is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_s_d  = ex_rd_s_i;
            wb_rd_we_d = ex_rd_we_i && (ex_rd_s_i != 5'd0);
            wb_rd_v_d  = ex_rd_v_i;
          end else if (ex_misal) begin
            // faulting access retires immediately without touching memory
            wb_valid_d = 1'b1;
            wb_rd_s_d  = ex_rd_s_i;
            wb_rd_v_d  = '0;
            misal_d    = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_ready_i) begin
          if (we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_s_d  = rd_s_q;
            wb_rd_v_d  = '0;
            state_d    = IDLE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (dmem.dmem_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_rd_s_d  = rd_s_q;
          wb_rd_we_d = rd_we_q && (rd_s_q != 5'd0);
          wb_rd_v_d  = ld_data;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_s_q  <= '0;
      rd_we_q <= 1'b0;
      lane_q  <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (cap_en) begin
      rd_s_q  <= ex_rd_s_i;
      rd_we_q <= ex_rd_we_i;
      lane_q  <= ex_lane;
      type_q  <= ex_ld_str_type_i;
      addr_q  <= {ex_addr[ADDRW-1:LW], {LW{1'b0}}};
      mask_q  <= ex_mask;
      wdata_q <= ex_wdata;
      we_q    <= ex_is_store_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_s_q  <= '0;
      wb_rd_we_q <= 1'b0;
      wb_rd_v_q  <= '0;
      misal_q    <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_s_q  <= wb_rd_s_d;
      wb_rd_we_q <= wb_rd_we_d;
      wb_rd_v_q  <= wb_rd_v_d;
      misal_q    <= misal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: request signals depend on state and captured data only
  // ---------------------------------------------------------------------------
  assign ex_ready_o        = (state_q == IDLE);
  assign dmem.dmem_valid_o = (state_q == REQ);
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_mask_o  = mask_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_we_o    = we_q;

  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_s_o    = wb_rd_s_q;
  assign wb_rd_we_o   = wb_rd_we_q;
  assign wb_rd_v_o    = wb_rd_v_q;
  assign misaligned_o = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores,
// misalignment, back-to-back issue and reset during an outstanding access.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_s_i = '0;
  logic        ex_rd_we_i = 1'b0;
  logic [31:0] ex_rd_v_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic        ex_is_store_i = 1'b0;
  logic [2:0]  ex_ld_str_type_i = '0;
  logic [31:0] ex_st_data_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_s_o;
  logic        wb_rd_we_o;
  logic [31:0] wb_rd_v_o;
  logic        misaligned_o;

  int checks   = 0;
  int failures = 0;

  mem_stage_if #(.XLEN(32), .ADDRW(32), .MASKW(4)) dmem ();

  mem_stage #(.XLEN(32), .ADDRW(32), .MASKW(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_rd_s_i        (ex_rd_s_i),
    .ex_rd_we_i       (ex_rd_we_i),
    .ex_rd_v_i        (ex_rd_v_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_is_store_i    (ex_is_store_i),
    .ex_ld_str_type_i (ex_ld_str_type_i),
    .ex_st_data_i     (ex_st_data_i),
    .dmem             (dmem.master),
    .wb_valid_o       (wb_valid_o),
    .wb_rd_s_o        (wb_rd_s_o),
    .wb_rd_we_o       (wb_rd_we_o),
    .wb_rd_v_o        (wb_rd_v_o),
    .misaligned_o     (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic ex_issue(input logic [4:0] rd, input logic we, input logic [31:0] v,
                          input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] sd);
    ex_valid_i       = 1'b1;
    ex_rd_s_i        = rd;
    ex_rd_we_i       = we;
    ex_rd_v_i        = v;
    ex_is_load_i     = ld;
    ex_is_store_i    = st;
    ex_ld_str_type_i = f3;
    ex_st_data_i     = sd;
  endtask

  task automatic ex_idle();
    ex_valid_i    = 1'b0;
    ex_is_load_i  = 1'b0;
    ex_is_store_i = 1'b0;
  endtask

  initial begin
    dmem.dmem_ready_i  = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = '0;

    // reset state
    step();
    step();
    check("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_dmem_valid", 32'(dmem.dmem_valid_o), 32'd0);
    check("rst_misaligned", 32'(misaligned_o), 32'd0);
    check("rst_wb_v", wb_rd_v_o, 32'd0);
    rst_i = 1'b1;
    step();

    // ADD rd=5: latency-1 writeback, stage stays ready
    ex_issue(5'd5, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 3'b000, 32'd0);
    step();
    ex_idle();
    check("add_wb_valid", 32'(wb_valid_o), 32'd1);
    check("add_wb_rd_s", 32'(wb_rd_s_o), 32'd5);
    check("add_wb_rd_we", 32'(wb_rd_we_o), 32'd1);
    check("add_wb_v", wb_rd_v_o, 32'h0000_1234);
    check("add_ex_ready", 32'(ex_ready_o), 32'd1);
    check("add_no_dmem", 32'(dmem.dmem_valid_o), 32'd0);
    step();
    check("add_wb_pulse_end", 32'(wb_valid_o), 32'd0);

    // ADD to x0 never writes
    ex_issue(5'd0, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 3'b000, 32'd0);
    step();
    ex_idle();
    check("x0_wb_valid", 32'(wb_valid_o), 32'd1);
    check("x0_wb_rd_we", 32'(wb_rd_we_o), 32'd0);

    // LB addr 0x1003 -> byte lane 3, sign-extended
    ex_issue(5'd7, 1'b1, 32'h0000_1003, 1'b1, 1'b0, 3'b000, 32'd0);
    step();
    ex_idle();
    check("lb_dmem_valid", 32'(dmem.dmem_valid_o), 32'd1);
    check("lb_addr", dmem.dmem_addr_o, 32'h0000_1000);
    check("lb_mask", 32'(dmem.dmem_mask_o), 32'h8);
    check("lb_we", 32'(dmem.dmem_we_o), 32'd0);
    check("lb_ex_ready", 32'(ex_ready_o), 32'd0);
    check("lb_no_wb", 32'(wb_valid_o), 32'd0);
    dmem.dmem_ready_i = 1'b1;
    step();
    check("lb_rsp_valid_low", 32'(dmem.dmem_valid_o), 32'd0);
    dmem.dmem_ready_i  = 1'b0;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h80FF_FF00;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    check("lb_wb_valid", 32'(wb_valid_o), 32'd1);
    check("lb_wb_rd_s", 32'(wb_rd_s_o), 32'd7);
    check("lb_wb_rd_we", 32'(wb_rd_we_o), 32'd1);
    check("lb_wb_v", wb_rd_v_o, 32'hFFFF_FF80);
    check("lb_ex_ready", 32'(ex_ready_o), 32'd1);

    // rvalid while idle is ignored
    dmem.dmem_rvalid_i = 1'b1;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    check("idle_rvalid_ignored", 32'(wb_valid_o), 32'd0);

    // LHU addr 0x2002, response 4 cycles after acceptance
    ex_issue(5'd8, 1'b1, 32'h0000_2002, 1'b1, 1'b0, 3'b101, 32'd0);
    step();
    ex_idle();
    check("lhu_addr", dmem.dmem_addr_o, 32'h0000_2000);
    check("lhu_mask", 32'(dmem.dmem_mask_o), 32'hC);
    dmem.dmem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      // ready held high in RSP must not disturb anything
      check("lhu_wait_ex_ready", 32'(ex_ready_o), 32'd0);
      check("lhu_wait_dmem_valid", 32'(dmem.dmem_valid_o), 32'd0);
      check("lhu_wait_wb_valid", 32'(wb_valid_o), 32'd0);
    end
    step();
    check("lhu_wait_ex_ready4", 32'(ex_ready_o), 32'd0);
    dmem.dmem_ready_i  = 1'b0;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'hBEEF_0000;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    check("lhu_wb_valid", 32'(wb_valid_o), 32'd1);
    check("lhu_wb_v", wb_rd_v_o, 32'h0000_BEEF);
    check("lhu_wb_rd_s", 32'(wb_rd_s_o), 32'd8);

    // SB addr 0x3001, ready held low 3 cycles, then back-to-back ADD
    ex_issue(5'd9, 1'b1, 32'h0000_3001, 1'b0, 1'b1, 3'b000, 32'h1234_56AA);
    for (int i = 0; i < 3; i++) begin
      step();
      ex_idle();
      check("sb_valid", 32'(dmem.dmem_valid_o), 32'd1);
      check("sb_addr", dmem.dmem_addr_o, 32'h0000_3000);
      check("sb_mask", 32'(dmem.dmem_mask_o), 32'h2);
      check("sb_wdata", dmem.dmem_wdata_o, 32'h0000_AA00);
      check("sb_we", 32'(dmem.dmem_we_o), 32'd1);
    end
    dmem.dmem_ready_i = 1'b1;
    step();
    dmem.dmem_ready_i = 1'b0;
    check("sb_wb_valid", 32'(wb_valid_o), 32'd1);
    check("sb_wb_rd_we", 32'(wb_rd_we_o), 32'd0);
    check("sb_ex_ready", 32'(ex_ready_o), 32'd1);
    ex_issue(5'd4, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 3'b000, 32'd0);
    step();
    ex_idle();
    check("b2b_wb_valid", 32'(wb_valid_o), 32'd1);
    check("b2b_wb_rd_s", 32'(wb_rd_s_o), 32'd4);
    check("b2b_wb_v", wb_rd_v_o, 32'h0000_BEEF);

    // LW addr 0x4002 is misaligned: immediate faulting writeback
    ex_issue(5'd6, 1'b1, 32'h0000_4002, 1'b1, 1'b0, 3'b010, 32'd0);
    step();
    ex_idle();
    check("lw_mis_dmem_valid", 32'(dmem.dmem_valid_o), 32'd0);
    check("lw_mis_wb_valid", 32'(wb_valid_o), 32'd1);
    check("lw_mis_wb_rd_we", 32'(wb_rd_we_o), 32'd0);
    check("lw_mis_flag", 32'(misaligned_o), 32'd1);
    check("lw_mis_ex_ready", 32'(ex_ready_o), 32'd1);
    step();
    check("lw_mis_flag_end", 32'(misaligned_o), 32'd0);

    // SH addr 0x5002: upper half lane
    ex_issue(5'd2, 1'b1, 32'h0000_5002, 1'b0, 1'b1, 3'b001, 32'hCAFE_BABE);
    step();
    ex_idle();
    check("sh_mask", 32'(dmem.dmem_mask_o), 32'hC);
    check("sh_wdata", dmem.dmem_wdata_o, 32'hBABE_0000);
    dmem.dmem_ready_i = 1'b1;
    step();
    dmem.dmem_ready_i = 1'b0;
    check("sh_wb_valid", 32'(wb_valid_o), 32'd1);
    check("sh_wb_rd_we", 32'(wb_rd_we_o), 32'd0);

    // LH addr 0x6000: lower half, sign-extended
    ex_issue(5'd10, 1'b1, 32'h0000_6000, 1'b1, 1'b0, 3'b001, 32'd0);
    step();
    ex_idle();
    check("lh_mask", 32'(dmem.dmem_mask_o), 32'h3);
    dmem.dmem_ready_i = 1'b1;
    step();
    dmem.dmem_ready_i  = 1'b0;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h1234_8001;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    check("lh_wb_v", wb_rd_v_o, 32'hFFFF_8001);

    // reset while in RSP drops the access
    ex_issue(5'd11, 1'b1, 32'h0000_7000, 1'b1, 1'b0, 3'b010, 32'd0);
    step();
    ex_idle();
    dmem.dmem_ready_i = 1'b1;
    step();
    dmem.dmem_ready_i = 1'b0;
    check("rsp_ex_ready_low", 32'(ex_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("rst_mid_ex_ready", 32'(ex_ready_o), 32'd1);
    check("rst_mid_wb_valid", 32'(wb_valid_o), 32'd0);
    step();
    rst_i = 1'b1;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'hDEAD_BEEF;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    check("rst_late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
    check("rst_late_ex_ready", 32'(ex_ready_o), 32'd1);
    ex_issue(5'd3, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 3'b000, 32'd0);
    step();
    ex_idle();
    check("post_rst_add_valid", 32'(wb_valid_o), 32'd1);
    check("post_rst_add_rd_s", 32'(wb_rd_s_o), 32'd3);
    check("post_rst_add_v", wb_rd_v_o, 32'h0000_0055);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
